// File: rtl/am2910_seq_datapath.sv
// Am2910-style sequencer datapath: uPC, register/counter R, LIFO return stack
// and the combinational next-address (Y) multiplexer.
module am2910_seq_datapath #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stack_op,
  input  logic [1:0]        rc_op,
  input  logic [1:0]        y_mux_sel,
  input  logic              y_zero,
  input  logic              ci,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] y,
  output logic [ADDR_W-1:0] upc,
  output logic [ADDR_W-1:0] tos,
  output logic [3:0]        sp,
  output logic              rc_is_zero,
  output logic              full_n
);

  localparam logic [3:0] DepthSp = 4'(DEPTH);

  typedef enum logic [1:0] {StkHold = 2'b00, StkPush = 2'b01, StkPop = 2'b10, StkClr = 2'b11} stk_op_e;
  typedef enum logic [1:0] {RcHold = 2'b00, RcLoad = 2'b01, RcDec = 2'b10, RcRsvd = 2'b11} rc_op_e;

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [3:0]        sp_q, sp_d;
  logic [ADDR_W-1:0] stk_q [DEPTH];
  logic              stk_we;
  logic [3:0]        stk_widx;

  // Top of stack: entry sp-1, or zero when the stack is empty.
  always_comb begin
    tos = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sp_q == 4'(i + 1)) tos = stk_q[i];
    end
  end

  // Next-address multiplexer; y_zero overrides the select.
  always_comb begin
    y = '0;
    if (!y_zero) begin
      unique case (y_mux_sel)
        2'b00:   y = upc_q;
        2'b01:   y = d;
        2'b10:   y = r_q;
        default: y = tos;
      endcase
    end
  end

  // uPC incrementer: next uPC is Y plus carry-in, wrapping at ADDR_W bits.
  always_comb begin
    upc_d = y + {{(ADDR_W - 1){1'b0}}, ci};
  end

  // Register/counter next state; the reserved code behaves as HOLD.
  always_comb begin
    r_d = r_q;
    unique case (rc_op_e'(rc_op))
      RcLoad:  r_d = d;
      RcDec:   r_d = r_q - {{(ADDR_W - 1){1'b0}}, 1'b1};
      default: r_d = r_q;
    endcase
  end

  // Stack pointer and write-port control. A push on a full stack overwrites
  // the top entry; a pop on an empty stack is ignored.
  always_comb begin
    sp_d     = sp_q;
    stk_we   = 1'b0;
    stk_widx = sp_q;
    unique case (stack_op_e_cast(stack_op))
      StkPush: begin
        stk_we = 1'b1;
        if (sp_q == DepthSp) begin
          stk_widx = DepthSp - 4'd1;
        end else begin
          sp_d = sp_q + 4'd1;
        end
      end
      StkPop: begin
        if (sp_q != 4'd0) sp_d = sp_q - 4'd1;
      end
      StkClr:  sp_d = 4'd0;
      default: sp_d = sp_q;
    endcase
  end

  function automatic stk_op_e stack_op_e_cast(input logic [1:0] op);
    return stk_op_e'(op);
  endfunction

  // Architectural state; reset wins over every op issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
      sp_q  <= 4'd0;
      for (int i = 0; i < int'(DEPTH); i++) stk_q[i] <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
      sp_q  <= sp_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (stk_we && (stk_widx == 4'(i))) stk_q[i] <= upc_q;
      end
    end
  end

  assign upc        = upc_q;
  assign sp         = sp_q;
  assign rc_is_zero = (r_q == '0);
  assign full_n     = (sp_q != DepthSp);

endmodule

// File: tb/tb_am2910_seq_datapath.sv
// Self-checking bench for am2910_seq_datapath: a behavioural model predicts
// each cycle's Y and post-edge state into a scoreboard queue.
module tb_am2910_seq_datapath;

  localparam int AW    = 12;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    stack_op, rc_op, y_mux_sel;
  logic          y_zero, ci;
  logic [AW-1:0] d;
  logic [AW-1:0] y, upc, tos;
  logic [3:0]    sp;
  logic          rc_is_zero, full_n;

  am2910_seq_datapath #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .stack_op   (stack_op),
    .rc_op      (rc_op),
    .y_mux_sel  (y_mux_sel),
    .y_zero     (y_zero),
    .ci         (ci),
    .d          (d),
    .y          (y),
    .upc        (upc),
    .tos        (tos),
    .sp         (sp),
    .rc_is_zero (rc_is_zero),
    .full_n     (full_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          chk_y;
    logic [AW-1:0] y;
    logic [AW-1:0] upc;
    logic [AW-1:0] tos;
    logic [3:0]    sp;
    logic          rcz;
    logic          full_n;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [AW-1:0] m_upc = '0;
  logic [AW-1:0] m_r   = '0;
  int            m_sp  = 0;
  logic [AW-1:0] m_stk [DEPTH];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, capture Y before the edge and
  // compare the registered state after it.
  task automatic cycle(input logic r, input logic [1:0] sop, input logic [1:0] rop,
                       input logic [1:0] sel, input logic yz, input logic cin,
                       input logic [AW-1:0] dv, input logic cy);
    exp_t          e;
    logic [AW-1:0] my, mf, y_obs;
    @(negedge clk);
    rst = r; stack_op = sop; rc_op = rop; y_mux_sel = sel; y_zero = yz; ci = cin; d = dv;
    mf = (m_sp > 0) ? m_stk[m_sp-1] : '0;
    if (yz) my = '0;
    else begin
      case (sel)
        2'b00:   my = m_upc;
        2'b01:   my = dv;
        2'b10:   my = m_r;
        default: my = mf;
      endcase
    end
    e.chk_y = cy;
    e.y     = my;
    if (r) begin
      m_upc = '0; m_r = '0; m_sp = 0;
      for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    end else begin
      case (sop)
        2'b01: begin
          if (m_sp < DEPTH) begin m_stk[m_sp] = m_upc; m_sp++; end
          else m_stk[DEPTH-1] = m_upc;
        end
        2'b10: if (m_sp > 0) m_sp--;
        2'b11: m_sp = 0;
        default: ;
      endcase
      if (rop == 2'b01) m_r = dv;
      else if (rop == 2'b10) m_r = m_r - 1'b1;
      m_upc = my + {{(AW-1){1'b0}}, cin};
    end
    e.upc    = m_upc;
    e.tos    = (m_sp > 0) ? m_stk[m_sp-1] : '0;
    e.sp     = 4'(m_sp);
    e.rcz    = (m_r == '0);
    e.full_n = (m_sp != DEPTH);
    sb.push_back(e);
    #1 y_obs = y;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (e.chk_y) check_val("y", 32'(y_obs), 32'(e.y));
      check_val("upc", 32'(upc), 32'(e.upc));
      check_val("tos", 32'(tos), 32'(e.tos));
      check_val("sp", 32'(sp), 32'(e.sp));
      check_val("rc_is_zero", 32'(rc_is_zero), 32'(e.rcz));
      check_val("full_n", 32'(full_n), 32'(e.full_n));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    rst = 1'b0; stack_op = 2'b00; rc_op = 2'b00; y_mux_sel = 2'b00;
    y_zero = 1'b0; ci = 1'b0; d = '0;

    // Reset: y selects d=0 so it is defined before state is
    cycle(1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 12'h000, 1'b1);
    // Continue: upc 1,2,3,4
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 12'h000, 1'b1);

    // Subroutine call/return
    cycle(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 12'h010, 1'b1);
    cycle(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 12'h200, 1'b1);
    cycle(1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 12'h000, 1'b1);

    // Overflow: push upc values 1..6, then underflow with 6 pops
    cycle(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 12'h001, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 12'h000, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 12'h000, 1'b1);

    // Counter: load 3, decrement through zero to all ones
    cycle(1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 12'h003, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 2'b00, 2'b11, 2'b10, 1'b0, 1'b0, 12'h000, 1'b1);

    // Simultaneous push+load, stack clear, forced-zero Y
    cycle(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 12'h0AB, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 12'h000, 1'b1);
    cycle(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 12'h000, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 12'h123, 1'b1);

    // uPC wrap
    cycle(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 12'hFFF, 1'b1);

    // Reset mid-operation with sp=3, R=7, upc=0x155
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 12'h000, 1'b1);
    cycle(1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 12'h155, 1'b1);
    cycle(1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 12'h007, 1'b1);
    cycle(1'b1, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 12'h000, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 12'h000, 1'b1);

    // Random mix, occasional reset
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            12'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
